mac_seq: RTL
============

# mac_seq

Operand sequencer and result collector that drives the 8-tap `MAC` accumulator from the initiator side. It holds two 8-entry operand banks that are loaded through a simple write port. On `start` it streams the eight (a,b) pairs into the MAC with a contiguous `mac_en` window. It then waits out the MAC pipeline, captures the MAC's 8-bit result and output address, and reports them with a one-cycle `done` pulse. It sits between the host/test controller and `MAC`.

## Interface
- `TAPS`, 8, operand pairs per job; fixed at 8 to match the MAC accumulate window.
- `W`, 8, operand and result width.
- `RES_LAT`, 11, cycles `mac_en` stays high per job; the MAC result is valid on the last of them. Must be ≥ `TAPS`+1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  operand write strobe.
- `wr_sel`  in  1  bank select: 0 = A bank, 1 = B bank.
- `wr_idx`  in  3  entry index 0..7.
- `wr_data`  in  W  operand value.
- `start`  in  1  job request, sampled only in IDLE.
- `job_addr`  in  3  tag for the job, latched on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` until the `done` cycle (exclusive).
- `done`  out  1  one-cycle pulse; `result` and `result_addr` are valid.
- `result`  out  W  captured MAC output; held until the next capture.
- `result_addr`  out  3  captured MAC `out_addr`; held.
- `mac_en`, `mac_a`, `mac_b`, `mac_addr`  out  1/W/W/3  drive MAC `mac_en`, `a`, `b`, `addr`.
- `mac_out`, `mac_out_addr`  in  W/3  from MAC `out`, `out_addr`.

## Operation
- States: IDLE, STREAM, DRAIN.
- Cycle counter `cnt` (0..RES_LAT-1) runs while `mac_en`=1.
- IDLE:
  - `mac_en`=0; `mac_a`/`mac_b`=0.
  - `start`=1 latches `job_addr`, clears `cnt`, and moves to STREAM.
  - `start` in any other state is ignored, not queued.
- STREAM:
  - `mac_en`=1, `mac_a`=A[cnt], `mac_b`=B[cnt], `mac_addr`=latched tag.
  - When `cnt`=TAPS-1, go to DRAIN.
- DRAIN:
  - `mac_en`=1, `mac_a`=`mac_b`=0, `mac_addr`=tag.
  - When `cnt`=RES_LAT-1, capture `mac_out`→`result` and `mac_out_addr`→`result_addr` at that edge, assert `done` next cycle, and return to IDLE.
- Operand writes:
  - Accepted only in IDLE.
  - Ignored while `busy`, so banks are stable for the whole job.
  - Bank contents persist across jobs.
- Arithmetic: none internally. Operands pass through unmodified; `result` is exactly `mac_out` sampled once.
- `mac_en` is guaranteed low for at least one cycle between jobs (the `done`/IDLE cycle), which clears the MAC accumulator.
- Reset (`rst`=0 at an edge), including mid-STREAM or mid-DRAIN:
  - state goes to IDLE, `cnt` to 0.
  - `busy`, `done`, `mac_en`, `mac_a`, `mac_b`, `mac_addr`, `result` and `result_addr` go to 0.
  - Operand banks go to 0.
  - No `done` is issued for the aborted job.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Accepted `start` at edge E0:
  - `mac_en`=1 in cycles E0+1 .. E0+RES_LAT, exactly RES_LAT cycles.
  - Pair k appears on `mac_a`/`mac_b` in cycle E0+1+k, for k=0..7.
  - `done`=1 in cycle E0+RES_LAT+1; default start-to-done is 12 cycles.
- `busy` is high in cycles E0+1 .. E0+RES_LAT.
- A `start` asserted in the `done` cycle is accepted (the state is IDLE). The next `mac_en` rises one cycle after `done`, giving back-to-back jobs every RES_LAT+1 cycles.
- A write in the same cycle as an accepted `start` is committed before streaming begins; bank reads use the registered contents from E0+1.
- `start` held continuously high restarts immediately after each `done`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random inputs → all outputs 0, `busy`=0, no `mac_en` activity.
- Single job: load A=1..8 and B=1..8, `start` with `job_addr`=5; bench MAC model returns `mac_out`=0xCC, `mac_out_addr`=5 on cycle E0+11 → `mac_a`/`mac_b` sequence 1..8 then three 0s; `mac_en` high exactly 11 cycles; `done` at E0+12 with `result`=0xCC and `result_addr`=5.
- Busy protection: during STREAM, pulse `start` and write A[0]=0xFF → no restart, `done` count = 1; the next job streams the original A[0].
- Reset mid-DRAIN: assert `rst`=0 at E0+9 → `mac_en`=0 next cycle, no `done`, `result`=0; a new job afterwards completes normally.
- Back-to-back: `start` held high for 3 jobs → `done` at E0+12, E0+24, E0+36; `mac_en` low exactly one cycle between windows.
- Bank select: A all 0x80, B all 0x7F, swap via `wr_sel` → `mac_a`=0x7F and `mac_b`=0x80 on every STREAM cycle.

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq: operand sequencer and result collector for the 8-tap MAC.
// Holds A/B operand banks, streams the pairs into the MAC over a contiguous
// mac_en window, waits out the MAC pipeline and returns the captured result.
//
// Handshake: start is a request sampled only while the sequencer is idle
// (busy low); a start seen while busy is dropped, not queued. Each accepted
// start produces exactly one done pulse RES_LAT+1 cycles later (unless reset
// intervenes), and result/result_addr are valid in that done cycle and held
// until the next capture.
module mac_seq #(
    parameter int TAPS    = 8,
    parameter int W       = 8,
    parameter int RES_LAT = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [2:0]   wr_idx,
    input  logic [W-1:0] wr_data,
    input  logic         start,
    input  logic [2:0]   job_addr,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [2:0]   result_addr,
    output logic         mac_en,
    output logic [W-1:0] mac_a,
    output logic [W-1:0] mac_b,
    output logic [2:0]   mac_addr,
    input  logic [W-1:0] mac_out,
    input  logic [2:0]   mac_out_addr,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(RES_LAT);
    localparam int IW = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    tag;
    logic [2:0]    tag_nxt;
    logic          capture;

    logic [W-1:0]  bank_a [TAPS];
    logic [W-1:0]  bank_b [TAPS];
    logic [W-1:0]  a_nxt  [TAPS];
    logic [W-1:0]  b_nxt  [TAPS];

    assign state_dbg = state;

    // Next state, cycle counter and job tag; capture fires on the last window cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tag_nxt   = tag;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    cnt_nxt   = '0;
                    tag_nxt   = job_addr;
                end
            end
            STREAM: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(TAPS - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == CW'(RES_LAT - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bank contents after this cycle's write; writes only land while idle,
    // and a write alongside an accepted start is visible to the first pair.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            a_nxt[i] = bank_a[i];
            b_nxt[i] = bank_b[i];
        end
        if (wr_en && (state == IDLE)) begin
            if (wr_sel) begin
                b_nxt[wr_idx] = wr_data;
            end else begin
                a_nxt[wr_idx] = wr_data;
            end
        end
    end

    // State, banks and every output registered from the next-state view.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tag         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_addr <= '0;
            mac_en      <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_addr    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tag   <= tag_nxt;
            for (int i = 0; i < TAPS; i++) begin
                bank_a[i] <= a_nxt[i];
                bank_b[i] <= b_nxt[i];
            end
            busy     <= (state_nxt != IDLE);
            mac_en   <= (state_nxt != IDLE);
            mac_addr <= (state_nxt != IDLE) ? tag_nxt : 3'd0;
            mac_a    <= (state_nxt == STREAM) ? a_nxt[cnt_nxt[IW-1:0]] : '0;
            mac_b    <= (state_nxt == STREAM) ? b_nxt[cnt_nxt[IW-1:0]] : '0;
            done     <= capture;
            if (capture) begin
                result      <= mac_out;
                result_addr <= mac_out_addr;
            end
        end
    end

endmodule
